// File: rtl/seg_display_mux.sv
// Four-digit multiplexed seven-segment driver for the MM:SS timer display.
// Digits are snapshotted once per frame; includes leading-zero blanking and whole-display blink.
module seg_display_mux #(
    parameter int TICK_COUNT   = 50000,
    parameter int BLINK_FRAMES = 32
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic [3:0] seconds_lower,
    input  logic [3:0] seconds_upper,
    input  logic [3:0] minutes_lower,
    input  logic [3:0] minutes_upper,
    input  logic       blank_leading,
    input  logic       blink,
    output logic [6:0] seg,
    output logic [3:0] AN
);

    localparam int TW = (TICK_COUNT > 1) ? $clog2(TICK_COUNT) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_COUNT - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

    typedef enum logic [1:0] {
        DIG0 = 2'd0,
        DIG1 = 2'd1,
        DIG2 = 2'd2,
        DIG3 = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
    logic [FW-1:0]   frame_cnt_q, frame_cnt_d;
    logic            blink_phase_q, blink_phase_d;
    logic            load_req_q;
    logic [3:0]      snap_sl_q, snap_su_q, snap_ml_q, snap_mu_q;
    logic [6:0]      seg_q, seg_d;
    logic [3:0]      an_q, an_d;

    logic            tick;
    logic            frame_wrap;
    logic            load;
    logic            dark;
    logic [3:0]      cur_digit;
    logic [3:0]      lit_an;

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h3F;
        endcase
        return s;
    endfunction

    always_comb begin
        tick       = (tick_cnt_q == TICK_LAST);
        frame_wrap = tick && (state_q == DIG3);
        load       = load_req_q || frame_wrap;
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

        state_d   = state_q;
        cur_digit = snap_sl_q;
        lit_an    = 4'b1110;
        case (state_q)
            DIG0: begin
                cur_digit = snap_sl_q;
                lit_an    = 4'b1110;
                if (tick) state_d = DIG1;
            end
            DIG1: begin
                cur_digit = snap_su_q;
                lit_an    = 4'b1101;
                if (tick) state_d = DIG2;
            end
            DIG2: begin
                cur_digit = snap_ml_q;
                lit_an    = 4'b1011;
                if (tick) state_d = DIG3;
            end
            default: begin
                cur_digit = snap_mu_q;
                lit_an    = 4'b0111;
                if (tick) state_d = DIG0;
            end
        endcase

        dark = blank_leading &&
               (((state_q == DIG3) && (snap_mu_q == 4'd0)) ||
                ((state_q == DIG2) && (snap_mu_q == 4'd0) && (snap_ml_q == 4'd0)));

        // The tick cycle is forced dark so the anode switch never ghosts the next digit.
        seg_d = decode(cur_digit);
        an_d  = (tick || dark || blink_phase_q) ? 4'hF : lit_an;

        frame_cnt_d   = frame_cnt_q;
        blink_phase_d = blink_phase_q;
        if (!blink) begin
            frame_cnt_d   = '0;
            blink_phase_d = 1'b0;
        end else if (frame_wrap) begin
            if (frame_cnt_q == FRAME_LAST) begin
                frame_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            tick_cnt_q    <= '0;
            state_q       <= DIG0;
            snap_sl_q     <= 4'd0;
            snap_su_q     <= 4'd0;
            snap_ml_q     <= 4'd0;
            snap_mu_q     <= 4'd0;
            frame_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            load_req_q    <= 1'b1;
            seg_q         <= 7'h7F;
            an_q          <= 4'hF;
        end else begin
            tick_cnt_q    <= tick_cnt_d;
            state_q       <= state_d;
            frame_cnt_q   <= frame_cnt_d;
            blink_phase_q <= blink_phase_d;
            load_req_q    <= 1'b0;
            seg_q         <= seg_d;
            an_q          <= an_d;
            if (load) begin
                snap_sl_q <= seconds_lower;
                snap_su_q <= seconds_upper;
                snap_ml_q <= minutes_lower;
                snap_mu_q <= minutes_upper;
            end
        end
    end

    assign seg = seg_q;
    assign AN  = an_q;

endmodule

// File: tb/tb_seg_display_mux.sv
// Directed bench for seg_display_mux with TICK_COUNT=4 (16-cycle frames) and BLINK_FRAMES=2.
module tb_seg_display_mux;

    logic       CLK = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] seconds_lower = 4'd7;
    logic [3:0] seconds_upper = 4'd8;
    logic [3:0] minutes_lower = 4'd6;
    logic [3:0] minutes_upper = 4'd9;
    logic       blank_leading = 1'b0;
    logic       blink = 1'b0;
    logic [6:0] seg;
    logic [3:0] AN;

    int total = 0;
    int bad   = 0;

    seg_display_mux #(
        .TICK_COUNT  (4),
        .BLINK_FRAMES(2)
    ) dut (
        .CLK          (CLK),
        .reset        (reset),
        .seconds_lower(seconds_lower),
        .seconds_upper(seconds_upper),
        .minutes_lower(minutes_lower),
        .minutes_upper(minutes_upper),
        .blank_leading(blank_leading),
        .blink        (blink),
        .seg          (seg),
        .AN           (AN)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // nlit cycles showing exp_an, then the dark guard cycle; seg holds the decode throughout.
    task automatic check_slot(input int nlit, input logic [3:0] exp_an,
                              input logic [6:0] exp_seg, input string tag);
        for (int i = 0; i < nlit; i++) begin
            step();
            chk({tag, "_an"}, {3'b0, AN}, {3'b0, exp_an});
            chk({tag, "_seg"}, seg, exp_seg);
        end
        step();
        chk({tag, "_guard_an"}, {3'b0, AN}, 7'h0F);
        chk({tag, "_guard_seg"}, seg, exp_seg);
    endtask

    task automatic frame4(input logic [3:0] a0, input logic [6:0] g0,
                          input logic [3:0] a1, input logic [6:0] g1,
                          input logic [3:0] a2, input logic [6:0] g2,
                          input logic [3:0] a3, input logic [6:0] g3,
                          input string tag);
        check_slot(3, a0, g0, {tag, "_d0"});
        check_slot(3, a1, g1, {tag, "_d1"});
        check_slot(3, a2, g2, {tag, "_d2"});
        check_slot(3, a3, g3, {tag, "_d3"});
    endtask

    initial begin
        // reset held with arbitrary inputs
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_seg", seg, 7'h7F);
            chk("rst_an", {3'b0, AN}, 7'h0F);
        end
        minutes_upper = 4'd1;
        minutes_lower = 4'd2;
        seconds_upper = 4'd3;
        seconds_lower = 4'd4;
        reset = 1'b1;

        // edge 1 loads the snapshot; digits valid from edge 2
        step();
        check_slot(2, 4'hE, 7'h19, "f0_d0");
        check_slot(3, 4'hD, 7'h30, "f0_d1");
        check_slot(3, 4'hB, 7'h24, "f0_d2");
        check_slot(3, 4'h7, 7'h79, "f0_d3");
        frame4(4'hE, 7'h19, 4'hD, 7'h30, 4'hB, 7'h24, 4'h7, 7'h79, "f1");

        // mid-frame change stays hidden until next frame
        check_slot(3, 4'hE, 7'h19, "f2_d0");
        check_slot(3, 4'hD, 7'h30, "f2_d1");
        seconds_lower = 4'd9;
        check_slot(3, 4'hB, 7'h24, "f2_d2");
        check_slot(3, 4'h7, 7'h79, "f2_d3");
        frame4(4'hE, 7'h10, 4'hD, 7'h30, 4'hB, 7'h24, 4'h7, 7'h79, "f3_snap");

        // invalid digit and zero minutes; blanking uses the old snapshot this frame
        seconds_lower = 4'hA;
        minutes_upper = 4'd0;
        minutes_lower = 4'd0;
        blank_leading = 1'b1;
        frame4(4'hE, 7'h10, 4'hD, 7'h30, 4'hB, 7'h24, 4'h7, 7'h79, "f4");

        check_slot(3, 4'hE, 7'h3F, "f5_d0");
        minutes_lower = 4'd5;
        check_slot(3, 4'hD, 7'h30, "f5_d1");
        check_slot(3, 4'hF, 7'h40, "f5_blank_d2");
        check_slot(3, 4'hF, 7'h40, "f5_blank_d3");
        frame4(4'hE, 7'h3F, 4'hD, 7'h30, 4'hB, 7'h12, 4'hF, 7'h40, "f6_blank");

        // blink: two frames lit, two dark
        blank_leading = 1'b0;
        blink = 1'b1;
        frame4(4'hE, 7'h3F, 4'hD, 7'h30, 4'hB, 7'h12, 4'h7, 7'h40, "f7_lit");
        frame4(4'hE, 7'h3F, 4'hD, 7'h30, 4'hB, 7'h12, 4'h7, 7'h40, "f8_lit");
        frame4(4'hF, 7'h3F, 4'hF, 7'h30, 4'hF, 7'h12, 4'hF, 7'h40, "f9_dark");
        frame4(4'hF, 7'h3F, 4'hF, 7'h30, 4'hF, 7'h12, 4'hF, 7'h40, "f10_dark");
        frame4(4'hE, 7'h3F, 4'hD, 7'h30, 4'hB, 7'h12, 4'h7, 7'h40, "f11_lit");
        frame4(4'hE, 7'h3F, 4'hD, 7'h30, 4'hB, 7'h12, 4'h7, 7'h40, "f12_lit");
        check_slot(3, 4'hF, 7'h3F, "f13_dark_d0");
        check_slot(3, 4'hF, 7'h30, "f13_dark_d1");

        // reset in the middle of the dark phase
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("rst2_seg", seg, 7'h7F);
            chk("rst2_an", {3'b0, AN}, 7'h0F);
        end
        reset = 1'b1;
        step();
        check_slot(2, 4'hE, 7'h3F, "r_d0");
        check_slot(3, 4'hD, 7'h30, "r_d1");
        check_slot(3, 4'hB, 7'h12, "r_d2");
        check_slot(3, 4'h7, 7'h40, "r_d3");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg_display_mux.md
# seg_display_mux

Four-digit multiplexed seven-segment driver that consumes the MM:SS BCD digit outputs of the kitchen-timer clock counter and drives the board's shared cathode bus `seg` and anode enables `AN`. It scans one digit per refresh slot and latches all four digits once per frame so that a single frame never mixes old and new values. It also provides leading-zero blanking and whole-display blinking, which the alarm/expired indication uses.

## Interface
- `TICK_COUNT`, default 50000, CLK cycles per digit slot (≥ 2)
- `BLINK_FRAMES`, default 32, full scan frames per blink half-period (≥ 1)

- `CLK`  in  1  system clock, all logic on rising edge
- `reset`  in  1  synchronous, active-low reset
- `seconds_lower`  in  4  BCD seconds units
- `seconds_upper`  in  4  BCD seconds tens
- `minutes_lower`  in  4  BCD minutes units
- `minutes_upper`  in  4  BCD minutes tens
- `blank_leading`  in  1  1 = suppress leading zero minute digits
- `blink`  in  1  1 = flash whole display
- `seg`  out  7  active-low segments {g,f,e,d,c,b,a}, registered
- `AN`  out  4  active-low anodes, AN[0] = seconds_lower … AN[3] = minutes_upper, registered

## Operation
- Reset (`reset`=0 at an edge): tick_cnt=0, state=DIG0, snapshot=0, frame_cnt=0, blink_phase=0, load_req=1, `seg`=7'h7F, `AN`=4'hF.
- Prescaler: tick_cnt counts 0..TICK_COUNT-1 then wraps. `tick` = (tick_cnt==TICK_COUNT-1).
- Scan FSM advances on `tick`: DIG0(seconds_lower, AN 1110) → DIG1(seconds_upper, 1101) → DIG2(minutes_lower, 1011) → DIG3(minutes_upper, 0111) → DIG0.
- Snapshot: all four inputs are captured together when load_req=1 (first cycle out of reset, which also clears load_req) or when `tick` occurs in DIG3 (frame wrap). Display logic reads only the snapshot.
- Decode (snapshot digit of the current state): 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78, 8→00, 9→10 (hex, 7-bit). Values 10–15 → 3F (dash, g only).
- Leading blank (blank_leading=1): DIG3 is dark if snap minutes_upper==0; DIG2 is dark if snap minutes_upper==0 and snap minutes_lower==0. DIG0 and DIG1 are never blanked.
- Blink: while `blink`=0, frame_cnt=0 and blink_phase=0. While `blink`=1, frame_cnt increments on each frame wrap. On reaching BLINK_FRAMES-1 at a wrap, frame_cnt wraps to 0 and blink_phase toggles. blink_phase=1 forces `AN`=F.
- A dark slot drives `AN`=F; `seg` still carries the decode.

## Timing
- Output registers update every cycle from the current state and snapshot. The outputs lag the FSM by 1 cycle.
- Anti-ghost guard: in the cycle where `tick`=1, `AN` is loaded with F. Each digit is therefore lit for TICK_COUNT-1 cycles and dark for 1 cycle per slot.
- Frame length = 4·TICK_COUNT cycles. Blink half-period = BLINK_FRAMES frames. The first dark phase starts BLINK_FRAMES frames after `blink` rises.
- After reset release, the snapshot is valid at edge 1 and outputs are valid from edge 2. The slot containing the release edge is DIG0.
- Input changes mid-frame are invisible until the next DIG3→DIG0 wrap. Changes coinciding with the wrap cycle are captured.
- Reset asserted mid-slot or mid-blink takes effect at the next edge and overrides `tick` and load.
- `blink` falling takes effect on the next edge: blink_phase clears, and display lights from the following slot update.

## Test plan
- Reset: hold `reset`=0 for 3 cycles with arbitrary inputs → `seg`=7F and `AN`=F on every cycle. Release → `AN`=E by edge 2.
- Scan order, TICK_COUNT=4, digits mu=1, ml=2, su=3, sl=4 → repeating sequence AN E/seg 19 for 3 cycles, F for 1 cycle, D/30, F, B/24, F, 7/79, F.
- Snapshot: same setup, change seconds_lower 4→9 during DIG2 → DIG0 of the next frame shows seg 10. Nothing changes earlier.
- Blanking: blank_leading=1, mu=0, ml=0 → AN never 7 or B. Set ml=5 → AN=B with seg 12 appears from the next frame, and AN 7 stays absent.
- Invalid digit: seconds_lower=4'hA → seg=3F in the DIG0 slot.
- Blink, BLINK_FRAMES=2: `blink`=1 → 2 frames lit, 2 frames with AN=F, repeating. Assert reset mid-dark-phase → AN=F/seg=7F, then normal lit scan after release.
